uart_rx_fifo: RTL and testbench

Receive-side buffer placed directly downstream of the UART receiver (`uartRs`). It captures each byte presented with the receiver's one-cycle `done` pulse into a synchronous FIFO. Bytes are handed to the consumer over a valid/ready stream. It also reports fill level, an almost-full warning, a sticky overflow flag and a saturating dropped-byte count, so that byte loss at the serial link is visible to software/control logic.

---
 rtl/uart_pkg.sv | 9 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_rx_fifo.sv | 75 +++++++
 tb/tb_uart_rx_fifo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default receive FIFO depth and byte type.
package uart_pkg;
    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    localparam uart_byte_t DROP_COUNT_MAX = 8'd255;
endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with wrap-bit pointers and a
// registered occupancy counter. A push into a full FIFO is accepted only with a same-cycle pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      level_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_s;
    logic             pop_s;

    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign pop_s   = rd_en && !empty;
    assign push_s  = wr_en && (!full || pop_s);
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
    assign level   = level_r;

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + ONE;
                2'b01:   level_r <= level_r - ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: queues each rx_done byte and reports
// occupancy, almost-full and byte loss (sticky overflow plus saturating drop count).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = UART_RX_FIFO_DEPTH,
    parameter int WIDTH       = UART_DATA_W,
    parameter int AFULL_LEVEL = 12,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_done,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [LW-1:0]    level,
    output logic             afull,
    output logic             overflow,
    output logic [7:0]       drop_count,
    input  logic             ovf_clear
);
    logic       full_s;
    logic       empty_s;
    logic       pop_s;
    logic       drop_s;
    logic       overflow_r;
    uart_byte_t drop_count_r;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_done),
        .wr_data (rx_data),
        .rd_en   (m_ready),
        .rd_data (m_data),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level)
    );

    assign m_valid    = !empty_s;
    assign pop_s      = m_valid && m_ready;
    assign drop_s     = rx_done && full_s && !pop_s;
    assign afull      = (level >= LW'(AFULL_LEVEL));
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

    // Loss accounting: a drop in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (ovf_clear) begin
                drop_count_r <= 8'd1;
            end else if (drop_count_r != DROP_COUNT_MAX) begin
                drop_count_r <= drop_count_r + 8'd1;
            end else begin
                drop_count_r <= drop_count_r;
            end
        end else if (ovf_clear) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else begin
            overflow_r   <= overflow_r;
            drop_count_r <= drop_count_r;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized stream,
// all compared against a queue-based model of the buffer's documented behaviour.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int AFL   = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [4:0] level;
    logic       afull;
    logic       overflow;
    logic [7:0] drop_count;
    logic       ovf_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         mdl_ovf = 1'b0;
    int         mdl_drops = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_LEVEL(AFL)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .level      (level),
        .afull      (afull),
        .overflow   (overflow),
        .drop_count (drop_count),
        .ovf_clear  (ovf_clear)
    );

    // One clock: drive inputs, advance the model by the buffer's rules, settle past the edge.
    task automatic cycle(input logic done, input logic [7:0] d, input logic rdy,
                         input logic clr, input logic r);
        bit pop, push, drop;
        rx_done = done; rx_data = d; m_ready = rdy; ovf_clear = clr; rst = r;
        pop  = (q.size() > 0) && rdy;
        push = done && ((q.size() < DEPTH) || pop);
        drop = done && !push;
        @(posedge clk);
        if (r) begin
            q.delete(); mdl_ovf = 1'b0; mdl_drops = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
            if (drop) begin
                mdl_ovf = 1'b1;
                mdl_drops = clr ? 1 : ((mdl_drops < 255) ? mdl_drops + 1 : 255);
            end else if (clr) begin
                mdl_ovf = 1'b0; mdl_drops = 0;
            end
        end
        #1;
        rx_done = 1'b0; m_ready = 1'b0; ovf_clear = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h want 0", m_data); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull got %0h want 0", afull); end
        checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL reset_ovf got %0h/%0d want 0/0", overflow, drop_count); end
    endtask

    task automatic test_basic();
        cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
            errors++; $display("FAIL basic_push got %0h/%0h want 1/a5", m_valid, m_data); end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL basic_level1 got %0d want 1", level); end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (m_valid !== 1'b0 || level !== 5'd0) begin
            errors++; $display("FAIL basic_pop got %0h/%0d want 0/0", m_valid, level); end
    endtask

    task automatic test_fill_order();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            checks++; if (level !== 5'(i + 1)) begin errors++; $display("FAIL fill_level got %0d want %0d", level, i + 1); end
            checks++; if (afull !== ((i + 1) >= AFL)) begin errors++; $display("FAIL fill_afull at %0d got %0h", i + 1, afull); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
                errors++; $display("FAIL drain_order got %0h want %0h", m_data, i); end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (m_valid !== 1'b0 || level !== 5'd0) begin
            errors++; $display("FAIL drain_empty got %0h/%0d want 0/0", m_valid, level); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1 || drop_count !== 8'd3) begin
            errors++; $display("FAIL ovf_three got %0h/%0d want 1/3", overflow, drop_count); end
        checks++; if (level !== 5'd16 || m_data !== 8'h10) begin
            errors++; $display("FAIL ovf_contents got %0d/%0h want 16/10", level, m_data); end
        cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin
            errors++; $display("FAIL ovf_clear_drop got %0h/%0d want 1/1", overflow, drop_count); end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL ovf_clear got %0h/%0d want 0/0", overflow, drop_count); end
    endtask

    task automatic test_full_pushpop();
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 5'd16 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL full_pp got %0d/%0h/%0d want 16/0/0", level, overflow, drop_count); end
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] exp;
            exp = (i < DEPTH - 1) ? 8'(8'h11 + i) : 8'h5A;
            checks++; if (m_data !== exp) begin errors++; $display("FAIL full_pp_order got %0h want %0h", m_data, exp); end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        checks++; if (drop_count !== 8'd255 || overflow !== 1'b1) begin
            errors++; $display("FAIL sat_count got %0d/%0h want 255/1", drop_count, overflow); end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] sent[$];
        logic [7:0] got[$];
        int guard;
        guard = 0;
        while ((sent.size() < 40 || q.size() > 0) && guard < 1000) begin
            logic       dn, rdy;
            logic [7:0] d;
            dn  = (sent.size() < 40) && (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            d   = 8'($urandom);
            if (dn) sent.push_back(d);
            if (m_valid && rdy) got.push_back(m_data);
            cycle(dn, d, rdy, 1'b0, 1'b0);
            guard++;
            checks++; if (level !== 5'(q.size())) begin errors++; $display("FAIL b2b_level got %0d want %0d", level, q.size()); end
            checks++; if (m_valid !== (q.size() != 0)) begin errors++; $display("FAIL b2b_valid got %0h want %0h", m_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if (m_data !== q[0]) begin errors++; $display("FAIL b2b_head got %0h want %0h", m_data, q[0]); end
            end
            checks++; if (overflow !== mdl_ovf || drop_count !== 8'(mdl_drops)) begin
                errors++; $display("FAIL b2b_ovf got %0h/%0d want %0h/%0d", overflow, drop_count, mdl_ovf, mdl_drops); end
        end
        checks++; if (guard >= 1000) begin errors++; $display("FAIL b2b_timeout got %0d want <1000", guard); end
        checks++; if (got != sent) begin errors++; $display("FAIL b2b_sequence got %0d bytes want %0d", got.size(), sent.size()); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 5'd5 || overflow !== 1'b1) begin
            errors++; $display("FAIL mid_setup got %0d/%0h want 5/1", level, overflow); end
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        checks++; if (m_valid !== 1'b0 || level !== 5'd0 || m_data !== 8'h00) begin
            errors++; $display("FAIL mid_reset got %0h/%0d/%0h want 0/0/0", m_valid, level, m_data); end
        checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL mid_reset_ovf got %0h/%0d want 0/0", overflow, drop_count); end
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h3C) begin
            errors++; $display("FAIL mid_push got %0h/%0h want 1/3c", m_valid, m_data); end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (m_valid !== 1'b0 || level !== 5'd0) begin
            errors++; $display("FAIL mid_pop got %0h/%0d want 0/0", m_valid, level); end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_fill_order();
        test_overflow();
        test_full_pushpop();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
